key_loader: RTL and testbench

KEY_LOADER -- requirements
Module: key_loader

---
 rtl/key_loader_pkg.sv | 14 +
 rtl/key_loader.sv | 108 ++++++++++
 tb/tb_key_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/key_loader_pkg.sv
// rtl/key_loader_pkg.sv - shared state encoding and default sizing for the key loader
package key_loader_pkg;

  localparam int KEY_W_DEF    = 8;
  localparam int MAX_FAIL_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE    = 2'd2,
    LOCKOUT = 2'd3
  } kl_state_e;

endpackage

// File: rtl/key_loader.sv
// rtl/key_loader.sv - serial key loader with even-parity check, reload and sticky lockout
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int MAX_FAIL = MAX_FAIL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             reload,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             key_err,
  output logic             lockout
);

  localparam int CNT_W  = $clog2(KEY_W + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  kl_state_e         r_state;
  logic [KEY_W-1:0]  r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_par;
  logic [KEY_W-1:0]  r_key;
  logic              r_key_valid;
  logic              r_key_err;
  logic              r_lockout;
  logic [FAIL_W-1:0] r_fail_cnt;

  logic              w_accept;
  logic              w_last;
  logic [FAIL_W-1:0] w_fail_inc;

  // s_ready depends on state only, never on s_valid
  assign s_ready    = (r_state == IDLE) || (r_state == SHIFT);
  assign w_accept   = s_valid && s_ready;
  assign w_last     = (r_bit_cnt == CNT_W'(KEY_W));
  assign w_fail_inc = (r_fail_cnt == FAIL_W'(MAX_FAIL)) ? r_fail_cnt
                                                        : r_fail_cnt + FAIL_W'(1);

  assign key       = r_key_valid ? r_key : '0;
  assign key_valid = r_key_valid;
  assign key_err   = r_key_err;
  assign lockout   = r_lockout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par       <= 1'b0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
      r_lockout   <= 1'b0;
      r_fail_cnt  <= '0;
    end else begin
      r_key_err <= 1'b0;
      case (r_state)
        IDLE, SHIFT: begin
          if (w_accept) begin
            if (w_last) begin
              r_bit_cnt <= '0;
              r_shift   <= '0;
              r_par     <= 1'b0;
              if (r_par ^ s_data) begin
                r_key_err  <= 1'b1;
                r_fail_cnt <= w_fail_inc;
                if (w_fail_inc == FAIL_W'(MAX_FAIL)) begin
                  r_lockout <= 1'b1;
                  r_state   <= LOCKOUT;
                end else begin
                  r_state <= IDLE;
                end
              end else begin
                r_key       <= r_shift;
                r_key_valid <= 1'b1;
                r_state     <= DONE;
              end
            end else begin
              // LSB arrives first, so bits enter at the top and walk down
              r_shift   <= {s_data, r_shift[KEY_W-1:1]};
              r_par     <= r_par ^ s_data;
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              r_state   <= SHIFT;
            end
          end
        end
        DONE: begin
          if (reload) begin
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        LOCKOUT: begin
          r_key       <= '0;
          r_key_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// tb/tb_key_loader.sv - directed and randomized frames checked against a frame-level model
module tb_key_loader;
  import key_loader_pkg::*;

  localparam int KW = 8;
  localparam int MF = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_data = 1'b0;
  logic          s_valid = 1'b0;
  logic          reload = 1'b0;
  logic          s_ready;
  logic [KW-1:0] key;
  logic          key_valid;
  logic          key_err;
  logic          lockout;

  int n_checks = 0;
  int n_err    = 0;

  logic [KW-1:0] m_key   = '0;
  bit            m_valid = 1'b0;
  bit            m_lock  = 1'b0;
  int            m_fail  = 0;

  key_loader #(.KEY_W(KW), .MAX_FAIL(MF)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .reload(reload), .key(key), .key_valid(key_valid), .key_err(key_err), .lockout(lockout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] exp_key();
    return (m_valid && !m_lock) ? m_key : '0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_key", key, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    m_key = '0; m_valid = 0; m_lock = 0; m_fail = 0;
    @(posedge clk); #1;
    chk("post_rst_s_ready", s_ready, 1);
  endtask

  task automatic send_frame(input logic [KW-1:0] d, input logic p, input int gap_max,
                            input bit reload_mid);
    bit exp_err;
    for (int i = 0; i <= KW; i++) begin
      int g;
      g = (gap_max > 0 && i > 0) ? int'($urandom_range(gap_max, 1)) : 0;
      repeat (g) begin s_valid = 1'b0; @(posedge clk); #1; end
      s_valid = 1'b1;
      s_data  = (i < KW) ? d[i] : p;
      reload  = reload_mid && (i == 2);
      @(posedge clk); #1;
      s_valid = 1'b0;
      reload  = 1'b0;
      if (i == 3) chk("key_mid_frame", key, exp_key());
    end
    exp_err = 1'b0;
    if (!m_valid && !m_lock) begin
      if ((($countones(d) + int'(p)) % 2) == 0) begin
        m_key = d; m_valid = 1;
      end else begin
        exp_err = 1'b1;
        m_fail  = (m_fail < MF) ? m_fail + 1 : MF;
        if (m_fail >= MF) m_lock = 1;
      end
    end
    chk("frame_key", key, exp_key());
    chk("frame_key_valid", key_valid, m_valid && !m_lock);
    chk("frame_key_err", key_err, exp_err);
    chk("frame_lockout", lockout, m_lock);
    chk("frame_s_ready", s_ready, !(m_valid || m_lock));
    @(posedge clk); #1;
    chk("err_one_cycle", key_err, 0);
    chk("hold_key", key, exp_key());
    chk("hold_s_ready", s_ready, !(m_valid || m_lock));
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    if (m_valid && !m_lock) m_valid = 0;
    chk("reload_key", key, exp_key());
    chk("reload_key_valid", key_valid, m_valid && !m_lock);
    chk("reload_s_ready", s_ready, !(m_valid || m_lock));
  endtask

  initial begin
    do_reset();

    send_frame(8'hA5, 1'b0, 0, 0);
    pulse_reload();
    send_frame(8'h0F, 1'b0, 0, 0);
    pulse_reload();

    send_frame(8'h3C, 1'b1, 0, 0);
    send_frame(8'h3C, 1'b0, 0, 0);
    pulse_reload();

    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    do_reset();
    send_frame(8'h81, 1'b0, 0, 0);
    pulse_reload();

    send_frame(8'h5A, 1'b0, 7, 0);
    pulse_reload();

    for (int n = 0; n < 12; n++) begin
      logic [KW-1:0] d;
      logic          p;
      d = KW'($urandom);
      p = (^d) ^ ($urandom_range(3, 0) == 0);
      send_frame(d, p, int'($urandom_range(3, 0)), !m_valid && ($urandom_range(1, 0) == 1));
      if ($urandom_range(2, 0) != 0) pulse_reload();
    end

    do_reset();
    send_frame(8'h3C, 1'b1, 0, 0);
    send_frame(8'h3C, 1'b1, 0, 0);
    send_frame(8'h3C, 1'b1, 0, 0);
    send_frame(8'hA5, 1'b0, 0, 0);
    pulse_reload();
    send_frame(8'hA5, 1'b0, 2, 0);
    do_reset();
    send_frame(8'hA5, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
